spike_servo_driver: RTL and testbench

Downstream stage of the LIF neuron. It counts the neuron's spike output over a fixed window to get a firing rate. It maps that rate linearly to a servo pulse width and generates a glitch-free hobby-servo PWM signal for one leg joint of the robo-dog. There is one instance per joint neuron.

---
 rtl/neuro_pkg.sv | 21 ++
 rtl/servo_pwm_gen.sv | 40 ++++
 rtl/spike_servo_driver.sv | 110 +++++++++++
 tb/tb_spike_servo_driver.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/neuro_pkg.sv
// Shared constants and helpers for the neuromorphic leg-joint pipeline.
package neuro_pkg;

  localparam int unsigned RATE_W_DEF     = 8;
  localparam int unsigned WIN_CYCLES_DEF = 1000000;  // 10 ms at 100 MHz
  localparam int unsigned PWM_PERIOD_DEF = 2000000;  // 20 ms servo frame
  localparam int unsigned PULSE_MIN_DEF  = 100000;   // 1.0 ms
  localparam int unsigned PULSE_MAX_DEF  = 200000;   // 2.0 ms
  localparam int unsigned STEP_DEF       = 400;

  // Bits needed to hold values 0..v-1, never less than 1.
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/servo_pwm_gen.sv
// Hobby-servo PWM generator; pulse width is only adopted on frame boundaries.
module servo_pwm_gen
  import neuro_pkg::*;
#(
  parameter int unsigned PWM_PERIOD = PWM_PERIOD_DEF,
  parameter int unsigned PULSE_MIN  = PULSE_MIN_DEF,
  parameter int unsigned PW         = clog2_min1(PWM_PERIOD)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [PW-1:0] width_next,
  output logic          pwm
);

  logic [PW-1:0] pwm_cnt;
  logic [PW-1:0] width_active;

  // Frame counter, boundary-latched width and registered drive output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt      <= '0;
      width_active <= PW'(PULSE_MIN);
      pwm          <= 1'b0;
    end else if (!enable) begin
      pwm_cnt      <= '0;
      width_active <= PW'(PULSE_MIN);
      pwm          <= 1'b0;
    end else begin
      pwm <= (pwm_cnt < width_active);
      if (pwm_cnt == PW'(PWM_PERIOD - 1)) begin
        pwm_cnt      <= '0;
        width_active <= width_next;
      end else begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_servo_driver.sv
// Spike-rate measurement over a fixed window, linear rate-to-pulse mapping
// and servo PWM drive for one robo-dog leg joint.
module spike_servo_driver
  import neuro_pkg::*;
#(
  parameter int unsigned WIN_CYCLES = WIN_CYCLES_DEF,
  parameter int unsigned PWM_PERIOD = PWM_PERIOD_DEF,
  parameter int unsigned PULSE_MIN  = PULSE_MIN_DEF,
  parameter int unsigned PULSE_MAX  = PULSE_MAX_DEF,
  parameter int unsigned STEP       = STEP_DEF,
  parameter int unsigned RATE_W     = RATE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spike,
  input  logic              enable,
  output logic [RATE_W-1:0] rate,
  output logic              rate_valid,
  output logic              rate_sat,
  output logic              pwm
);

  localparam int unsigned WW    = clog2_min1(WIN_CYCLES);
  localparam int unsigned PW    = clog2_min1(PWM_PERIOD);
  localparam int unsigned PROD_W = RATE_W + clog2_min1(STEP) + 1;
  localparam int unsigned MAP_W = ((PROD_W > PW) ? PROD_W : PW) + 1;

  if (!(PULSE_MIN <= PULSE_MAX && PULSE_MAX < PWM_PERIOD)) begin : g_bad_pulse
    $error("spike_servo_driver: need PULSE_MIN <= PULSE_MAX < PWM_PERIOD");
  end
  if (WIN_CYCLES < 2) begin : g_bad_win
    $error("spike_servo_driver: WIN_CYCLES must be at least 2");
  end
  if (STEP < 1) begin : g_bad_step
    $error("spike_servo_driver: STEP must be at least 1");
  end

  logic [WW-1:0]     win_cnt;
  logic [RATE_W-1:0] acc;
  logic              sat;
  logic [PW-1:0]     width_next;
  logic [MAP_W-1:0]  mapped;
  logic              terminal;
  logic              acc_max;
  logic              acc_inc;
  logic              hit_sat;

  // Terminal-cycle detect and saturating-increment decode.
  always_comb begin
    terminal = (win_cnt == WW'(WIN_CYCLES - 1));
    acc_max  = (acc == '1);
    acc_inc  = spike & ~acc_max;
    hit_sat  = spike & acc_max;
    mapped   = MAP_W'(PULSE_MIN) + MAP_W'(rate) * MAP_W'(STEP);
  end

  // Window counter, spike accumulator and end-of-window rate latch.
  // A spike in the terminal cycle is folded into the closing window's rate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_cnt    <= '0;
      acc        <= '0;
      sat        <= 1'b0;
      rate       <= '0;
      rate_valid <= 1'b0;
      rate_sat   <= 1'b0;
    end else if (!enable) begin
      win_cnt    <= '0;
      acc        <= '0;
      sat        <= 1'b0;
      rate_valid <= 1'b0;
    end else if (terminal) begin
      win_cnt    <= '0;
      acc        <= '0;
      sat        <= 1'b0;
      rate       <= acc + RATE_W'(acc_inc);
      rate_sat   <= sat | hit_sat;
      rate_valid <= 1'b1;
    end else begin
      win_cnt    <= win_cnt + 1'b1;
      acc        <= acc + RATE_W'(acc_inc);
      sat        <= sat | hit_sat;
      rate_valid <= 1'b0;
    end
  end

  // Clamped linear rate-to-width mapping, one cycle behind the rate register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      width_next <= PW'(PULSE_MIN);
    end else if (mapped > MAP_W'(PULSE_MAX)) begin
      width_next <= PW'(PULSE_MAX);
    end else begin
      width_next <= mapped[PW-1:0];
    end
  end

  servo_pwm_gen #(
    .PWM_PERIOD (PWM_PERIOD),
    .PULSE_MIN  (PULSE_MIN),
    .PW         (PW)
  ) u_pwm (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .width_next (width_next),
    .pwm        (pwm)
  );

endmodule

// File: tb/tb_spike_servo_driver.sv
// Randomized bench for spike_servo_driver: two instances (window 10 and 20)
// share stimulus and are compared every cycle against a spike-count model.
module tb_spike_servo_driver;

  localparam int PERIOD = 20;
  localparam int PMIN   = 4;
  localparam int PMAX   = 12;
  localparam int STEPV  = 2;
  localparam int RMAX   = 15;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic spike = 1'b0;
  logic enable = 1'b0;

  logic [3:0] rate_a, rate_b;
  logic       valid_a, valid_b, sat_a, sat_b, pwm_a, pwm_b;

  int total = 0;
  int bad = 0;

  // model state per instance
  int winlen [2];
  int n [2];
  int cnt [2];
  int m_rate [2];
  int m_sat [2];
  int m_valid [2];
  int m_pwm [2];
  int m_wn [2];
  int m_wa [2];

  always #5 clk = ~clk;

  spike_servo_driver #(
    .WIN_CYCLES (10), .PWM_PERIOD (PERIOD), .PULSE_MIN (PMIN),
    .PULSE_MAX (PMAX), .STEP (STEPV), .RATE_W (4)
  ) dut_a (
    .clk (clk), .reset (reset), .spike (spike), .enable (enable),
    .rate (rate_a), .rate_valid (valid_a), .rate_sat (sat_a), .pwm (pwm_a)
  );

  spike_servo_driver #(
    .WIN_CYCLES (20), .PWM_PERIOD (PERIOD), .PULSE_MIN (PMIN),
    .PULSE_MAX (PMAX), .STEP (STEPV), .RATE_W (4)
  ) dut_b (
    .clk (clk), .reset (reset), .spike (spike), .enable (enable),
    .rate (rate_b), .rate_valid (valid_b), .rate_sat (sat_b), .pwm (pwm_b)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int width_of(input int r);
    int w;
    w = PMIN + r * STEPV;
    return (w > PMAX) ? PMAX : w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      n[i] = 0; cnt[i] = 0; m_rate[i] = 0; m_sat[i] = 0; m_valid[i] = 0;
      m_pwm[i] = 0; m_wn[i] = PMIN; m_wa[i] = PMIN;
    end
  endtask

  // Expected outputs after the next rising edge given this cycle's inputs.
  task automatic model_step(input bit en, input bit sp);
    for (int i = 0; i < 2; i++) begin
      int old_rate;
      old_rate = m_rate[i];
      if (!en) begin
        n[i] = 0; cnt[i] = 0; m_valid[i] = 0; m_pwm[i] = 0; m_wa[i] = PMIN;
      end else begin
        m_pwm[i] = ((n[i] % PERIOD) < m_wa[i]) ? 1 : 0;
        if ((n[i] % PERIOD) == PERIOD - 1) m_wa[i] = m_wn[i];
        cnt[i] += sp ? 1 : 0;
        if ((n[i] % winlen[i]) == winlen[i] - 1) begin
          m_rate[i]  = (cnt[i] > RMAX) ? RMAX : cnt[i];
          m_sat[i]   = (cnt[i] > RMAX) ? 1 : 0;
          m_valid[i] = 1;
          cnt[i]     = 0;
        end else begin
          m_valid[i] = 0;
        end
        n[i]++;
      end
      m_wn[i] = width_of(old_rate);
    end
  endtask

  task automatic compare_all();
    check_val("rate_a", int'(rate_a), m_rate[0]);
    check_val("valid_a", int'(valid_a), m_valid[0]);
    check_val("sat_a", int'(sat_a), m_sat[0]);
    check_val("pwm_a", int'(pwm_a), m_pwm[0]);
    check_val("rate_b", int'(rate_b), m_rate[1]);
    check_val("valid_b", int'(valid_b), m_valid[1]);
    check_val("sat_b", int'(sat_b), m_sat[1]);
    check_val("pwm_b", int'(pwm_b), m_pwm[1]);
  endtask

  // Drive one cycle at the falling edge, check at the following one.
  task automatic run_cycle(input bit en, input bit sp);
    enable = en;
    spike  = sp;
    model_step(en, sp);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    bit hit;
    winlen[0] = 10;
    winlen[1] = 20;
    model_reset();

    // reset values
    reset = 1'b0;
    repeat (2) @(negedge clk);
    compare_all();
    reset = 1'b1;

    // idle spiking: rate 0, pwm 4 of 20
    for (int c = 0; c < 60; c++) run_cycle(1'b1, 1'b0);

    // three spikes per short window, one in the terminal cycle
    for (int c = 0; c < 100; c++) begin
      int p;
      p = n[0] % 10;
      run_cycle(1'b1, (p == 2 || p == 5 || p == 9));
    end

    // continuous spiking: clamp on short window, saturation on long one
    for (int c = 0; c < 80; c++) run_cycle(1'b1, 1'b1);

    // random rates, widths change mid-frame
    for (int c = 0; c < 200; c++) run_cycle(1'b1, ($urandom_range(0, 2) == 0));

    // disable after two spikes, re-enable with no spikes
    run_cycle(1'b1, 1'b1);
    run_cycle(1'b1, 1'b1);
    for (int c = 0; c < 4; c++) run_cycle(1'b0, 1'b0);
    for (int c = 0; c < 60; c++) run_cycle(1'b1, 1'b0);

    // random enable toggling with random spikes
    for (int c = 0; c < 400; c++)
      run_cycle(($urandom_range(0, 30) != 0), ($urandom_range(0, 1) == 1));

    // async reset while pwm is high
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      run_cycle(1'b1, ($urandom_range(0, 1) == 1));
      if (m_pwm[0] == 1 && int'(pwm_a) == 1) hit = 1'b1;
    end
    check_val("pwm_high_wait", int'(hit), 1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    compare_all();
    reset = 1'b1;

    for (int c = 0; c < 150; c++)
      run_cycle(($urandom_range(0, 40) != 0), ($urandom_range(0, 3) != 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
